// File: rtl/dmem_responder_if.sv
// D-mem request/response bundle between the LSP initiator (master) and dmem_responder (slave).
interface dmem_responder_if;
   logic [63:0] dm_req_addr;
   logic [63:0] dm_req_wdata;
   logic [7:0]  dm_req_wmask;
   logic        dm_req_wen;
   logic        dm_req_valid;
   logic [63:0] dm_resp_rdata;
   logic        dm_resp_valid;
   logic        dm_resp_err;
   logic        proto_err;
   logic        busy;

   modport master (
      output dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
      input  dm_resp_rdata, dm_resp_valid, dm_resp_err, proto_err, busy
   );

   modport slave (
      input  dm_req_addr, dm_req_wdata, dm_req_wmask, dm_req_wen, dm_req_valid,
      output dm_resp_rdata, dm_resp_valid, dm_resp_err, proto_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory target for the LSP D-mem interface: byte-masked stores, 64-bit loads, programmable latency.
// Optional random stall injection when DMEM_RESPONDER_LFSR_STALL_EN is defined.
module dmem_responder #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
   parameter int unsigned LATENCY   = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave dm
);
   localparam int unsigned DEPTH    = 1 << ADDR_W;
   localparam logic [64:0] END_ADDR = {1'b0, BASE_ADDR} + (65'(DEPTH) << 3);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wen_q, wen_d;
   logic              inr_q, inr_d;
   logic [63:0]       rdata_q, rdata_d;
   logic              proto_q, proto_d;

   logic [63:0]       mem_q [DEPTH];

   logic              accept;
   logic              req_in_range;
   logic [ADDR_W-1:0] req_idx;
   logic [1:0]        extra;
   logic [4:0]        total_lat;

   assign accept       = dm.dm_req_valid && (state_q == IDLE || state_q == RESP);
   assign req_in_range = (dm.dm_req_addr >= BASE_ADDR) && ({1'b0, dm.dm_req_addr} < END_ADDR);
   // BASE_ADDR is DEPTH*8 aligned, so the word index is simply the low address bits.
   assign req_idx      = dm.dm_req_addr[ADDR_W+2:3];

`ifdef DMEM_RESPONDER_LFSR_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign extra  = lfsr_q[1:0];

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= LFSR_SEED;
      else     lfsr_q <= lfsr_d;
   end
`else
   assign extra = 2'd0;
`endif

   assign total_lat = 5'(LATENCY) + 5'(extra);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wen_q   <= 1'b0;
         inr_q   <= 1'b0;
         rdata_q <= '0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         inr_q   <= inr_d;
         rdata_q <= rdata_d;
         proto_q <= proto_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, RESP: begin
            if (!accept) begin
               state_d = IDLE;
            end else if (total_lat == 5'd1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
               cnt_d   = total_lat - 5'd2;
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 5'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Every transition into RESP is an entry (RESP->RESP only via a new accept), and the
   // _d copies hold the live request on accept, so one read path covers both cases.
   always_comb begin
      idx_d   = idx_q;
      wen_d   = wen_q;
      inr_d   = inr_q;
      rdata_d = rdata_q;
      proto_d = proto_q | (dm.dm_req_valid && state_q == WAIT);
      if (accept) begin
         idx_d = req_idx;
         wen_d = dm.dm_req_wen;
         inr_d = req_in_range;
      end
      if (state_d == RESP) begin
         rdata_d = (wen_d || !inr_d) ? '0 : mem_q[idx_d];
      end
   end

   always_comb begin
      dm.dm_resp_valid = (state_q == RESP);
      dm.dm_resp_err   = (state_q == RESP) && !inr_q;
      dm.busy          = (state_q == WAIT) || (state_q == RESP && dm.dm_req_valid);
      dm.dm_resp_rdata = rdata_q;
      dm.proto_err     = proto_q;
   end

   always_ff @(posedge clk) begin
      if (accept && dm.dm_req_wen && req_in_range) begin
         for (int unsigned b = 0; b < 8; b++) begin
            if (dm.dm_req_wmask[b]) mem_q[req_idx][8*b +: 8] <= dm.dm_req_wdata[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 1/3/4) against a word-array reference model.
module tb_dmem_responder;
   localparam int unsigned AW    = 8;
   localparam int unsigned NW    = 1 << AW;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LIMIT = BASE + 64'(NW) * 64'd8;
`ifdef DMEM_RESPONDER_LFSR_STALL_EN
   localparam int EXTRA_MAX = 3;
`else
   localparam int EXTRA_MAX = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] req_addr, req_wdata;
   logic [7:0]  req_wmask;
   logic        req_wen;
   logic [2:0]  req_valid;
   int          tests = 0;
   int          fails = 0;
   int          sel = 0;

   logic [63:0] mem_m [3][NW];

   dmem_responder_if if_l1 ();
   dmem_responder_if if_l3 ();
   dmem_responder_if if_l4 ();

   assign if_l1.dm_req_addr = req_addr;  assign if_l1.dm_req_wdata = req_wdata;
   assign if_l1.dm_req_wmask = req_wmask; assign if_l1.dm_req_wen = req_wen;
   assign if_l1.dm_req_valid = req_valid[0];
   assign if_l3.dm_req_addr = req_addr;  assign if_l3.dm_req_wdata = req_wdata;
   assign if_l3.dm_req_wmask = req_wmask; assign if_l3.dm_req_wen = req_wen;
   assign if_l3.dm_req_valid = req_valid[1];
   assign if_l4.dm_req_addr = req_addr;  assign if_l4.dm_req_wdata = req_wdata;
   assign if_l4.dm_req_wmask = req_wmask; assign if_l4.dm_req_wen = req_wen;
   assign if_l4.dm_req_valid = req_valid[2];

   dmem_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(1), .LFSR_SEED(16'hACE1))
      dut_l1 (.clk(clk), .rst(rst), .dm(if_l1.slave));
   dmem_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(3), .LFSR_SEED(16'hACE1))
      dut_l3 (.clk(clk), .rst(rst), .dm(if_l3.slave));
   dmem_responder #(.ADDR_W(AW), .BASE_ADDR(BASE), .LATENCY(4), .LFSR_SEED(16'hACE1))
      dut_l4 (.clk(clk), .rst(rst), .dm(if_l4.slave));

   always #5 clk = ~clk;

   logic [63:0] o_rdata;
   logic        o_valid, o_err, o_proto, o_busy;
   always_comb begin
      case (sel)
         0: begin
            o_rdata = if_l1.dm_resp_rdata; o_valid = if_l1.dm_resp_valid; o_err = if_l1.dm_resp_err;
            o_proto = if_l1.proto_err;     o_busy  = if_l1.busy;
         end
         1: begin
            o_rdata = if_l3.dm_resp_rdata; o_valid = if_l3.dm_resp_valid; o_err = if_l3.dm_resp_err;
            o_proto = if_l3.proto_err;     o_busy  = if_l3.busy;
         end
         default: begin
            o_rdata = if_l4.dm_resp_rdata; o_valid = if_l4.dm_resp_valid; o_err = if_l4.dm_resp_err;
            o_proto = if_l4.proto_err;     o_busy  = if_l4.busy;
         end
      endcase
   end

   function automatic int lat_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
   endfunction

   // Reference: a flat word array; out-of-range stores vanish, out-of-range loads read zero.
   task automatic model_req(input int s, input logic [63:0] a, wd, input logic [7:0] m, input logic w,
                            output logic [63:0] er, output logic ee);
      logic        inr;
      int unsigned wi;
      inr = (a >= BASE) && (a < LIMIT);
      wi  = 32'((a - BASE) >> 3);
      ee  = !inr;
      er  = '0;
      if (inr && w) begin
         for (int b = 0; b < 8; b++) if (m[b]) mem_m[s][wi][8*b +: 8] = wd[8*b +: 8];
      end else if (inr) begin
         er = mem_m[s][wi];
      end
   endtask

   task automatic drive(input int s, input logic [63:0] a, wd, input logic [7:0] m, input logic w);
      req_addr = a; req_wdata = wd; req_wmask = m; req_wen = w;
      req_valid = 3'(1 << s);
   endtask

   // One request, then watch until the response has come and gone (bounded); lat=0 means no response arrived.
   task automatic transact(input int s, input logic [63:0] a, wd, input logic [7:0] m, input logic w,
                           output int lat, output logic [63:0] rd, output logic er, output int dup);
      int n;
      bit stop;
      sel = s; lat = 0; dup = 0; rd = 'x; er = 1'bx; n = 0; stop = 0;
      drive(s, a, wd, m, w);
      @(posedge clk); #1;
      req_valid = '0;
      while (!stop) begin
         n++;
         @(negedge clk);
         if (o_valid === 1'b1) begin
            if (lat == 0) begin lat = n; rd = o_rdata; er = o_err; end
            else dup++;
         end else if (lat != 0) begin
            stop = 1;
         end
         if (n >= 24) stop = 1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         tests++;
         if ({o_valid, o_err, o_proto, o_busy} !== 4'b0 || o_rdata !== 64'h0) begin
            fails++;
            $display("FAIL reset[%0d]: valid=%b err=%b proto=%b busy=%b rdata=%h, want all 0",
                     s, o_valid, o_err, o_proto, o_busy, o_rdata);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_init();
      int lat, dup; logic [63:0] rd, er; logic ee, e;
      for (int s = 0; s < 3; s++) begin
         for (int w = 0; w < NW; w++) begin
            logic [63:0] a, wd;
            a  = BASE + 64'(w) * 64'd8;
            wd = {$urandom, $urandom};
            model_req(s, a, wd, 8'hFF, 1'b1, er, ee);
            transact(s, a, wd, 8'hFF, 1'b1, lat, rd, e, dup);
            tests++;
            if (lat < lat_of(s) || lat > lat_of(s) + EXTRA_MAX || rd !== er || e !== ee || dup != 0) begin
               fails++;
               $display("FAIL init[%0d][%0d]: lat=%0d rdata=%h err=%b dup=%0d, want lat %0d..%0d rdata=%h err=%b dup=0",
                        s, w, lat, rd, e, dup, lat_of(s), lat_of(s) + EXTRA_MAX, er, ee);
            end
         end
      end
   endtask

   task automatic test_store_load();
      int lat, dup; logic [63:0] rd, er; logic ee, e;
      logic [63:0] a;
      a = 64'h8000_0008;
      model_req(0, a, 64'h0, 8'hFF, 1'b1, er, ee);
      transact(0, a, 64'h0, 8'hFF, 1'b1, lat, rd, e, dup);
      model_req(0, a, 64'h1122334455667788, 8'h0F, 1'b1, er, ee);
      transact(0, a, 64'h1122334455667788, 8'h0F, 1'b1, lat, rd, e, dup);
      tests++;
      if (lat < 1 || lat > 1 + EXTRA_MAX || rd !== 64'h0 || e !== 1'b0 || dup != 0) begin
         fails++;
         $display("FAIL store_resp: lat=%0d rdata=%h err=%b dup=%0d, want lat 1..%0d rdata=0 err=0",
                  lat, rd, e, dup, 1 + EXTRA_MAX);
      end
      model_req(0, a, 64'h0, 8'h00, 1'b0, er, ee);
      transact(0, a, 64'h0, 8'h00, 1'b0, lat, rd, e, dup);
      tests++;
      if (lat < 1 || lat > 1 + EXTRA_MAX || rd !== 64'h0000000055667788 || rd !== er || e !== 1'b0 || dup != 0) begin
         fails++;
         $display("FAIL load_after_store: lat=%0d rdata=%h err=%b dup=%0d, want lat 1..%0d rdata=0000000055667788 err=0",
                  lat, rd, e, dup, 1 + EXTRA_MAX);
      end
   endtask

   task automatic test_latency3();
      int pos, busy_bad; logic [63:0] rd, er; logic ee, bz;
      logic [63:0] a;
      a = BASE + 64'($urandom_range(0, NW - 1)) * 64'd8;
      sel = 1; pos = 0; busy_bad = 0; bz = 1'bx; rd = 'x;
      model_req(1, a, 64'h0, 8'h00, 1'b0, er, ee);
      drive(1, a, 64'h0, 8'h00, 1'b0);
      @(posedge clk); #1;
      req_valid = '0;
      for (int n = 1; n <= 12 && pos == 0; n++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin pos = n; rd = o_rdata; bz = o_busy; end
         else if (o_busy !== 1'b1) busy_bad++;
         @(posedge clk); #1;
      end
      tests++;
      if (pos < 3 || pos > 3 + EXTRA_MAX) begin
         fails++; $display("FAIL lat3_position: response at +%0d, want +3..+%0d", pos, 3 + EXTRA_MAX);
      end
      tests++;
      if (busy_bad != 0) begin
         fails++; $display("FAIL lat3_busy_wait: %0d waiting cycles with busy=0, want 0", busy_bad);
      end
      tests++;
      if (rd !== er || bz !== 1'b0) begin
         fails++; $display("FAIL lat3_resp: rdata=%h busy=%b, want rdata=%h busy=0", rd, bz, er);
      end
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL lat3_after: valid=%b busy=%b, want 0 0", o_valid, o_busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_rd [8];
      logic        exp_er [8];
      logic [63:0] a, wd;
      logic [7:0]  m;
      logic        w;
      a = BASE + 64'h10; sel = 0;
`ifndef DMEM_RESPONDER_LFSR_STALL_EN
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            w = (i % 2 == 0); wd = {$urandom, $urandom}; m = 8'($urandom);
            drive(0, a, wd, m, w);
            model_req(0, a, wd, m, w, exp_rd[i], exp_er[i]);
         end else begin
            req_valid = '0;
         end
         if (i >= 1) begin
            @(negedge clk);
            tests++;
            if (o_valid !== 1'b1 || o_rdata !== exp_rd[i-1] || o_err !== exp_er[i-1] || o_busy !== (i < 8)) begin
               fails++;
               $display("FAIL b2b[%0d]: valid=%b rdata=%h err=%b busy=%b, want 1 %h %b %b",
                        i - 1, o_valid, o_rdata, o_err, o_busy, exp_rd[i-1], exp_er[i-1], (i < 8));
            end
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_tail: valid=%b, want 0", o_valid);
      end
      @(posedge clk); #1;
`else
      for (int i = 0; i < 8; i++) begin
         int lat, dup; logic [63:0] rd; logic e;
         w = (i % 2 == 0); wd = {$urandom, $urandom}; m = 8'($urandom);
         model_req(0, a, wd, m, w, exp_rd[i], exp_er[i]);
         transact(0, a, wd, m, w, lat, rd, e, dup);
         tests++;
         if (lat < 1 || lat > 4 || rd !== exp_rd[i] || e !== exp_er[i] || dup != 0) begin
            fails++;
            $display("FAIL b2b_serial[%0d]: lat=%0d rdata=%h err=%b dup=%0d, want lat 1..4 rdata=%h err=%b",
                     i, lat, rd, e, dup, exp_rd[i], exp_er[i]);
         end
      end
`endif
   endtask

   task automatic test_random();
      int lat, dup, s; logic [63:0] rd, er, a, wd; logic ee, e, w; logic [7:0] m;
      for (int i = 0; i < 150; i++) begin
         s  = (i < 100) ? 0 : int'($urandom_range(0, 2));
         a  = BASE - 64'd1024 + 64'($urandom_range(0, 4095));
         wd = {$urandom, $urandom};
         m  = 8'($urandom);
         w  = ($urandom_range(0, 2) == 0);
         model_req(s, a, wd, m, w, er, ee);
         transact(s, a, wd, m, w, lat, rd, e, dup);
         tests++;
         if (lat < lat_of(s) || lat > lat_of(s) + EXTRA_MAX || rd !== er || e !== ee || dup != 0) begin
            fails++;
            $display("FAIL random[%0d] dut%0d addr=%h wen=%b: lat=%0d rdata=%h err=%b dup=%0d, want lat %0d..%0d rdata=%h err=%b",
                     i, s, a, w, lat, rd, e, dup, lat_of(s), lat_of(s) + EXTRA_MAX, er, ee);
         end
      end
   endtask

   task automatic test_out_of_range();
      int lat, dup; logic [63:0] rd; logic e;
      transact(0, 64'h7FFF_FFF8, 64'h0, 8'h00, 1'b0, lat, rd, e, dup);
      tests++;
      if (lat < 1 || lat > 1 + EXTRA_MAX || rd !== 64'h0 || e !== 1'b1 || dup != 0) begin
         fails++; $display("FAIL oor_load: lat=%0d rdata=%h err=%b, want rdata=0 err=1", lat, rd, e);
      end
      transact(0, LIMIT, {$urandom, $urandom}, 8'hFF, 1'b1, lat, rd, e, dup);
      tests++;
      if (lat < 1 || lat > 1 + EXTRA_MAX || rd !== 64'h0 || e !== 1'b1 || dup != 0) begin
         fails++; $display("FAIL oor_store: lat=%0d rdata=%h err=%b, want rdata=0 err=1", lat, rd, e);
      end
      for (int w = 0; w < NW; w++) begin
         transact(0, BASE + 64'(w) * 64'd8, 64'h0, 8'h00, 1'b0, lat, rd, e, dup);
         tests++;
         if (rd !== mem_m[0][w] || e !== 1'b0 || lat == 0) begin
            fails++; $display("FAIL readback[%0d]: rdata=%h err=%b lat=%0d, want %h err=0", w, rd, e, lat, mem_m[0][w]);
         end
      end
   endtask

   task automatic test_proto();
      int pulses, pos, lat, dup; logic [63:0] rd, er, a, a2; logic ee, e;
      a  = BASE + 64'($urandom_range(0, NW / 2 - 1)) * 64'd8;
      a2 = BASE + 64'($urandom_range(NW / 2, NW - 1)) * 64'd8;
      sel = 2; pulses = 0; pos = 0; rd = 'x;
      tests++;
      if (o_proto !== 1'b0) begin
         fails++; $display("FAIL proto_clean: proto_err=%b, want 0", o_proto);
      end
      model_req(2, a, 64'h0, 8'h00, 1'b0, er, ee);
      drive(2, a, 64'h0, 8'h00, 1'b0);
      @(posedge clk); #1;
      drive(2, a2, ~mem_m[2][32'((a2 - BASE) >> 3)], 8'hFF, 1'b1);
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (o_valid === 1'b1) begin pulses++; if (pos == 0) begin pos = n; rd = o_rdata; end end
         @(posedge clk); #1;
         req_valid = '0;
      end
      tests++;
      if (pulses != 1 || pos < 4 || pos > 4 + EXTRA_MAX || rd !== er) begin
         fails++;
         $display("FAIL proto_single_resp: pulses=%0d at +%0d rdata=%h, want 1 at +4..+%0d rdata=%h",
                  pulses, pos, rd, 4 + EXTRA_MAX, er);
      end
      tests++;
      if (o_proto !== 1'b1) begin
         fails++; $display("FAIL proto_set: proto_err=%b, want 1", o_proto);
      end
      model_req(2, a2, 64'h0, 8'h00, 1'b0, er, ee);
      transact(2, a2, 64'h0, 8'h00, 1'b0, lat, rd, e, dup);
      tests++;
      if (rd !== er || o_proto !== 1'b1) begin
         fails++; $display("FAIL proto_ignored_store: rdata=%h proto_err=%b, want %h 1", rd, o_proto, er);
      end
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      drive(2, a, 64'h0, 8'h00, 1'b0);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      tests++;
      if (o_busy !== 1'b1) begin
         fails++; $display("FAIL rerun_busy: busy=%b, want 1", o_busy);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (o_valid === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      tests++;
      if (pulses != 0 || o_proto !== 1'b0 || o_busy !== 1'b0) begin
         fails++; $display("FAIL reset_drop: pulses=%0d proto_err=%b busy=%b, want 0 0 0", pulses, o_proto, o_busy);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wmask = '0; req_wen = 1'b0;
      test_reset();
      test_init();
      test_store_load();
      test_latency3();
      test_back_to_back();
      test_random();
      test_out_of_range();
      test_proto();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
